bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory_controller slave port.
// Ownership is held for the owner's whole CYC; a watchdog aborts strobes that are never acknowledged.
module bus_arbiter #(
  parameter int DATA_SIZE      = 32,
  parameter int ADDR_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   m0_CYC_I,
  input  logic                   m0_STB_I,
  input  logic                   m0_WE_I,
  input  logic [DATA_SIZE/8-1:0] m0_SEL_I,
  input  logic [ADDR_SIZE-1:0]   m0_ADR_I,
  input  logic [DATA_SIZE-1:0]   m0_DAT_I,
  output logic [DATA_SIZE-1:0]   m0_DAT_O,
  output logic                   m0_ACK_O,
  output logic                   m0_ERR_O,
  input  logic                   m1_CYC_I,
  input  logic                   m1_STB_I,
  input  logic                   m1_WE_I,
  input  logic [DATA_SIZE/8-1:0] m1_SEL_I,
  input  logic [ADDR_SIZE-1:0]   m1_ADR_I,
  input  logic [DATA_SIZE-1:0]   m1_DAT_I,
  output logic [DATA_SIZE-1:0]   m1_DAT_O,
  output logic                   m1_ACK_O,
  output logic                   m1_ERR_O,
  output logic                   s_CYC_O,
  output logic                   s_STB_O,
  output logic                   s_WE_O,
  output logic [DATA_SIZE/8-1:0] s_SEL_O,
  output logic [ADDR_SIZE-1:0]   s_ADR_O,
  output logic [DATA_SIZE-1:0]   s_DAT_O,
  input  logic [DATA_SIZE-1:0]   s_DAT_I,
  input  logic                   s_ACK_I,
  output logic [1:0]             gnt_O
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_q;
  logic [WD_W-1:0]   wd_cnt_q;

  logic own_cyc;
  logic own_stb;
  logic abort;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state_q)
      GNT0: begin
        own_cyc = m0_CYC_I;
        own_stb = m0_STB_I;
      end
      GNT1: begin
        own_cyc = m1_CYC_I;
        own_stb = m1_STB_I;
      end
      default: ;
    endcase
  end

  // An ACK landing on the threshold cycle completes normally.
  assign abort = (TIMEOUT_CYCLES != 0) && own_stb && !s_ACK_I && (wd_cnt_q == WD_LAST);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_CYC_I && m1_CYC_I) state_q <= last_q ? GNT0 : GNT1;
          else if (m0_CYC_I)        state_q <= GNT0;
          else if (m1_CYC_I)        state_q <= GNT1;
        end
        GNT0: begin
          if (!m0_CYC_I) begin
            last_q  <= 1'b0;
            state_q <= m1_CYC_I ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!m1_CYC_I) begin
            last_q  <= 1'b1;
            state_q <= m0_CYC_I ? GNT0 : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Owner dropping CYC is exactly when the grant changes.
      if ((TIMEOUT_CYCLES == 0) || !own_cyc || !own_stb || s_ACK_I || abort)
        wd_cnt_q <= '0;
      else if (wd_cnt_q != '1)
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  assign gnt_O = {state_q == GNT1, state_q == GNT0};

  always_comb begin
    s_CYC_O  = 1'b0;
    s_STB_O  = 1'b0;
    s_WE_O   = 1'b0;
    s_SEL_O  = '0;
    s_ADR_O  = '0;
    s_DAT_O  = '0;
    m0_DAT_O = '0;
    m0_ACK_O = 1'b0;
    m0_ERR_O = 1'b0;
    m1_DAT_O = '0;
    m1_ACK_O = 1'b0;
    m1_ERR_O = 1'b0;
    case (state_q)
      GNT0: begin
        s_CYC_O  = m0_CYC_I && !abort;
        s_STB_O  = m0_STB_I && !abort;
        s_WE_O   = m0_WE_I;
        s_SEL_O  = m0_SEL_I;
        s_ADR_O  = m0_ADR_I;
        s_DAT_O  = m0_DAT_I;
        m0_DAT_O = s_DAT_I;
        m0_ACK_O = s_ACK_I;
        m0_ERR_O = abort;
      end
      GNT1: begin
        s_CYC_O  = m1_CYC_I && !abort;
        s_STB_O  = m1_STB_I && !abort;
        s_WE_O   = m1_WE_I;
        s_SEL_O  = m1_SEL_I;
        s_ADR_O  = m1_ADR_I;
        s_DAT_O  = m1_DAT_I;
        m1_DAT_O = s_DAT_I;
        m1_ACK_O = s_ACK_I;
        m1_ERR_O = abort;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, back-to-back alternation sequence,
// then random traffic checked against a transaction-level owner/wait-count model.
module tb_bus_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          RST_I;
  logic          m0_CYC_I, m0_STB_I, m0_WE_I;
  logic [SW-1:0] m0_SEL_I;
  logic [AW-1:0] m0_ADR_I;
  logic [DW-1:0] m0_DAT_I, m0_DAT_O;
  logic          m0_ACK_O, m0_ERR_O;
  logic          m1_CYC_I, m1_STB_I, m1_WE_I;
  logic [SW-1:0] m1_SEL_I;
  logic [AW-1:0] m1_ADR_I;
  logic [DW-1:0] m1_DAT_I, m1_DAT_O;
  logic          m1_ACK_O, m1_ERR_O;
  logic          s_CYC_O, s_STB_O, s_WE_O;
  logic [SW-1:0] s_SEL_O;
  logic [AW-1:0] s_ADR_O;
  logic [DW-1:0] s_DAT_O, s_DAT_I;
  logic          s_ACK_I;
  logic [1:0]    gnt_O;

  always #5 clk = ~clk;

  bus_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_I(clk), .RST_I(RST_I),
    .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I), .m0_SEL_I(m0_SEL_I),
    .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I), .m0_DAT_O(m0_DAT_O), .m0_ACK_O(m0_ACK_O),
    .m0_ERR_O(m0_ERR_O),
    .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I), .m1_SEL_I(m1_SEL_I),
    .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I), .m1_DAT_O(m1_DAT_O), .m1_ACK_O(m1_ACK_O),
    .m1_ERR_O(m1_ERR_O),
    .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_SEL_O(s_SEL_O),
    .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I),
    .gnt_O(gnt_O)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner (-1 = nobody), last served master, consecutive waiting cycles.
  int m_own  = -1;
  int m_last = 1;
  int m_wait = 0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit chk);
    logic       cyc [2];
    logic       stb [2];
    bit         ab;
    logic [1:0] eg;
    logic [70:0] es;
    logic [33:0] e0, e1;
    cyc[0] = m0_CYC_I; cyc[1] = m1_CYC_I;
    stb[0] = m0_STB_I; stb[1] = m1_STB_I;
    ab = 1'b0;
    if (m_own >= 0 && TO > 0)
      ab = stb[m_own] && !s_ACK_I && (m_wait + 1 == TO);
    eg = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    es = '0; e0 = '0; e1 = '0;
    if (m_own == 0) begin
      es = {m0_CYC_I & ~ab, m0_STB_I & ~ab, m0_WE_I, m0_SEL_I, m0_ADR_I, m0_DAT_I};
      e0 = {s_ACK_I, ab, s_DAT_I};
    end else if (m_own == 1) begin
      es = {m1_CYC_I & ~ab, m1_STB_I & ~ab, m1_WE_I, m1_SEL_I, m1_ADR_I, m1_DAT_I};
      e1 = {s_ACK_I, ab, s_DAT_I};
    end
    if (chk) begin
      cmp("gnt", 128'(gnt_O), 128'(eg));
      cmp("s_bus", 128'({s_CYC_O, s_STB_O, s_WE_O, s_SEL_O, s_ADR_O, s_DAT_O}), 128'(es));
      cmp("m0_resp", 128'({m0_ACK_O, m0_ERR_O, m0_DAT_O}), 128'(e0));
      cmp("m1_resp", 128'({m1_ACK_O, m1_ERR_O, m1_DAT_O}), 128'(e1));
    end
    if (RST_I) begin
      m_own = -1; m_last = 1; m_wait = 0;
    end else begin
      if (m_own >= 0 && cyc[m_own] && stb[m_own] && !s_ACK_I && !ab) m_wait = m_wait + 1;
      else m_wait = 0;
      if (m_own < 0) begin
        if (cyc[0] && cyc[1]) m_own = 1 - m_last;
        else if (cyc[0])      m_own = 0;
        else if (cyc[1])      m_own = 1;
      end else if (!cyc[m_own]) begin
        m_last = m_own;
        m_own  = cyc[1 - m_own] ? 1 - m_own : -1;
      end
    end
  endtask

  task automatic tick(input bit chk);
    @(negedge clk);
    model_step(chk);
    @(posedge clk);
    #1;
  endtask

  // in = {rst, c0, s0, c1, s1, ack}; o = {s_cyc, ack0, ack1, err0, err1}
  typedef struct {
    logic [5:0] in;
    logic [1:0] g;
    logic [4:0] o;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic [5:0] in, input logic [1:0] g, input logic [4:0] o);
    vec_t v;
    v.in = in; v.g = g; v.o = o;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   rem [2];
    bit   drop [2];
    int   acks [2];
    int   own_now;
    logic [1:0] runs[$];
    logic [1:0] prev;

    RST_I = 1'b1;
    m0_CYC_I = 0; m0_STB_I = 0; m0_WE_I = 1; m0_SEL_I = 4'hF;
    m0_ADR_I = 32'h0100_0000; m0_DAT_I = 32'hA5A5_0001;
    m1_CYC_I = 0; m1_STB_I = 0; m1_WE_I = 0; m1_SEL_I = 4'h3;
    m1_ADR_I = 32'h2000_0010; m1_DAT_I = 32'h5A5A_0002;
    s_DAT_I = 32'hDEAD_BEEF; s_ACK_I = 0;
    tick(0);
    tick(0);

    // single m0 write, slave busy for 2 cycles
    add(1, 6'b0_11_00_0, 2'b00, 5'b0_0000);
    add(2, 6'b0_11_00_0, 2'b01, 5'b1_0000);
    add(1, 6'b0_11_00_1, 2'b01, 5'b1_1000);
    add(1, 6'b0_00_00_0, 2'b01, 5'b0_0000);
    add(1, 6'b0_00_00_0, 2'b00, 5'b0_0000);
    // simultaneous request after reset, handoff with no idle cycle
    add(1, 6'b1_00_00_0, 2'b00, 5'b0_0000);
    add(1, 6'b0_11_11_0, 2'b00, 5'b0_0000);
    add(1, 6'b0_11_11_1, 2'b01, 5'b1_1000);
    add(1, 6'b0_00_11_0, 2'b01, 5'b0_0000);
    add(1, 6'b0_00_11_1, 2'b10, 5'b1_0100);
    add(1, 6'b0_00_00_0, 2'b10, 5'b0_0000);
    add(1, 6'b0_00_00_0, 2'b00, 5'b0_0000);
    // m1 locks across 3 strobes while m0 waits
    add(1, 6'b0_00_11_0, 2'b00, 5'b0_0000);
    add(1, 6'b0_11_11_1, 2'b10, 5'b1_0100);
    add(1, 6'b0_11_10_0, 2'b10, 5'b1_0000);
    add(2, 6'b0_11_11_1, 2'b10, 5'b1_0100);
    add(1, 6'b0_11_00_0, 2'b10, 5'b0_0000);
    add(1, 6'b0_11_00_1, 2'b01, 5'b1_1000);
    add(1, 6'b0_00_00_0, 2'b01, 5'b0_0000);
    add(1, 6'b0_00_00_0, 2'b00, 5'b0_0000);
    // never acknowledged: ERR in the 8th waiting cycle only
    add(1, 6'b0_11_00_0, 2'b00, 5'b0_0000);
    add(7, 6'b0_11_00_0, 2'b01, 5'b1_0000);
    add(1, 6'b0_11_00_0, 2'b01, 5'b0_0010);
    add(1, 6'b0_00_00_0, 2'b01, 5'b0_0000);
    add(1, 6'b0_00_00_0, 2'b00, 5'b0_0000);
    // ACK on the threshold cycle wins
    add(1, 6'b0_11_00_0, 2'b00, 5'b0_0000);
    add(7, 6'b0_11_00_0, 2'b01, 5'b1_0000);
    add(1, 6'b0_11_00_1, 2'b01, 5'b1_1000);
    add(1, 6'b0_00_00_0, 2'b01, 5'b0_0000);
    add(1, 6'b0_00_00_0, 2'b00, 5'b0_0000);
    // reset while m1 owns the bus; late ACK dropped; m0 then wins the tie
    add(1, 6'b0_00_11_0, 2'b00, 5'b0_0000);
    add(1, 6'b0_00_11_0, 2'b10, 5'b1_0000);
    add(1, 6'b1_00_11_0, 2'b10, 5'b1_0000);
    add(1, 6'b0_11_11_1, 2'b00, 5'b0_0000);
    add(1, 6'b0_11_11_0, 2'b01, 5'b1_0000);
    add(1, 6'b0_00_11_0, 2'b01, 5'b0_0000);
    add(1, 6'b0_00_00_0, 2'b10, 5'b0_0000);
    add(1, 6'b0_00_00_0, 2'b00, 5'b0_0000);

    for (int i = 0; i < tbl.size(); i++) begin
      {RST_I, m0_CYC_I, m0_STB_I, m1_CYC_I, m1_STB_I, s_ACK_I} = tbl[i].in;
      @(negedge clk);
      cmp($sformatf("tbl%0d_gnt", i), 128'(gnt_O), 128'(tbl[i].g));
      cmp($sformatf("tbl%0d_flags", i),
          128'({s_CYC_O, m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O}), 128'(tbl[i].o));
      model_step(1);
      @(posedge clk);
      #1;
    end

    // back-to-back: 4 single transfers per master, CYC dropped one cycle after each ACK
    {RST_I, m0_CYC_I, m0_STB_I, m1_CYC_I, m1_STB_I, s_ACK_I} = 6'b1_00_00_0;
    tick(1);
    RST_I = 1'b0;
    rem[0] = 4; rem[1] = 4; drop[0] = 0; drop[1] = 0; acks[0] = 0; acks[1] = 0;
    prev = 2'b00;
    for (int c = 0; c < 40; c++) begin
      m0_CYC_I = (rem[0] > 0) && !drop[0]; m0_STB_I = m0_CYC_I;
      m1_CYC_I = (rem[1] > 0) && !drop[1]; m1_STB_I = m1_CYC_I;
      own_now  = m_own;
      s_ACK_I  = (own_now == 0) ? m0_STB_I : (own_now == 1) ? m1_STB_I : 1'b0;
      @(negedge clk);
      if (m0_ACK_O) acks[0]++;
      if (m1_ACK_O) acks[1]++;
      if (gnt_O != 2'b00 && gnt_O != prev) runs.push_back(gnt_O);
      prev = gnt_O;
      model_step(1);
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        drop[n] = 0;
        if (own_now == n && s_ACK_I) begin
          rem[n]--;
          drop[n] = 1;
        end
      end
    end
    cmp("b2b_acks_m0", 128'(acks[0]), 128'(4));
    cmp("b2b_acks_m1", 128'(acks[1]), 128'(4));
    cmp("b2b_grant_runs", 128'(runs.size()), 128'(8));
    for (int i = 0; i < runs.size() && i < 8; i++)
      cmp($sformatf("b2b_run%0d", i), 128'(runs[i]), 128'((i % 2) ? 2'b10 : 2'b01));

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      RST_I = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) m0_CYC_I = ~m0_CYC_I;
      if ($urandom_range(0, 7) == 0) m1_CYC_I = ~m1_CYC_I;
      m0_STB_I = m0_CYC_I && ($urandom_range(0, 3) != 0);
      m1_STB_I = m1_CYC_I && ($urandom_range(0, 3) != 0);
      m0_WE_I = 1'($urandom); m1_WE_I = 1'($urandom);
      m0_SEL_I = 4'($urandom); m1_SEL_I = 4'($urandom);
      m0_ADR_I = $urandom; m1_ADR_I = $urandom;
      m0_DAT_I = $urandom; m1_DAT_I = $urandom;
      s_DAT_I = $urandom;
      s_ACK_I = ($urandom_range(0, 3) == 0);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
